// File: rtl/frac_clken_gen.sv
`default_nettype none
// ============================================================================
// frac_clken_gen : multi-channel NUM/DEN clock-enable generator with runtime reprogramming
// Revision: 1.0
// ============================================================================
module frac_clken_gen #(
    parameter int CHANNELS    = 2,
    parameter int ACC_W       = 16,
    parameter int INIT_NUM    = 1,
    parameter int INIT_DEN    = 2,
    parameter int LOCK_PULSES = 2,
    localparam int CH_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clkin,
    input  logic                rst_n,
    input  logic                sync,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [CH_W-1:0]     cfg_ch,
    input  logic [ACC_W-1:0]    cfg_num,
    input  logic [ACC_W-1:0]    cfg_den,
    output logic                cfg_err,
    output logic [CHANNELS-1:0] ce,
    output logic [CHANNELS-1:0] clkdiv,
    output logic [CHANNELS-1:0] locked
);

    localparam logic [ACC_W-1:0] C_INIT_NUM    = ACC_W'(INIT_NUM);
    localparam logic [ACC_W-1:0] C_INIT_DEN    = ACC_W'(INIT_DEN);
    localparam logic [CH_W:0]    C_CHANNELS    = (CH_W+1)'(CHANNELS);
    localparam logic [3:0]       C_LOCK_PULSES = 4'(LOCK_PULSES);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_PEND = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic                r_cfg_err;
    logic [CH_W-1:0]     r_pend_ch;
    logic [ACC_W-1:0]    r_pend_num;
    logic [ACC_W-1:0]    r_pend_den;
    logic                w_req;
    logic                w_bad;
    logic                w_accept;
    logic                w_apply_any;
    logic [CHANNELS-1:0] w_apply;

    // cfg_ready is a pure decode of the state register, so it stays registered
    assign cfg_ready   = (r_state == S_IDLE);
    assign cfg_err     = r_cfg_err;
    assign w_req       = cfg_valid & cfg_ready;
    assign w_bad       = (cfg_den == '0) || (cfg_num > cfg_den) || ({1'b0, cfg_ch} >= C_CHANNELS);
    assign w_accept    = w_req & ~w_bad;
    assign w_apply_any = |w_apply;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_next = S_PEND;
            S_PEND:  if (w_apply_any) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_cfg_err  <= 1'b0;
            r_pend_ch  <= '0;
            r_pend_num <= '0;
            r_pend_den <= '0;
        end else begin
            r_state   <= w_state_next;
            r_cfg_err <= w_req & w_bad;
            if (w_accept) begin
                r_pend_ch  <= cfg_ch;
                r_pend_num <= cfg_num;
                r_pend_den <= cfg_den;
            end
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic [ACC_W-1:0] r_acc;
        logic [ACC_W-1:0] r_num;
        logic [ACC_W-1:0] r_den;
        logic             r_ce;
        logic             r_clkdiv;
        logic             r_locked;
        logic [3:0]       r_lock_cnt;
        logic [ACC_W:0]   w_sum;
        logic             w_hit;
        logic             w_accept_here;
        logic [3:0]       w_cnt_inc;

        assign w_sum         = {1'b0, r_acc} + {1'b0, r_num};
        assign w_hit         = (w_sum >= {1'b0, r_den});
        assign w_apply[i]    = (r_state == S_PEND) && (r_pend_ch == CH_W'(i)) && (w_hit || (r_num == '0));
        assign w_accept_here = w_accept && (cfg_ch == CH_W'(i));
        assign w_cnt_inc     = (r_lock_cnt == 4'hF) ? r_lock_cnt : r_lock_cnt + 4'd1;

        // s - den always fits ACC_W bits, so the modular subtract is exact
        always_ff @(posedge clkin or negedge rst_n) begin
            if (!rst_n) begin
                r_acc      <= '0;
                r_num      <= C_INIT_NUM;
                r_den      <= C_INIT_DEN;
                r_ce       <= 1'b0;
                r_clkdiv   <= 1'b0;
                r_locked   <= 1'b0;
                r_lock_cnt <= '0;
            end else begin
                if (w_apply[i]) begin
                    r_num      <= r_pend_num;
                    r_den      <= r_pend_den;
                    r_acc      <= '0;
                    r_lock_cnt <= '0;
                    r_locked   <= 1'b0;
                    if (sync) begin
                        r_ce     <= 1'b0;
                        r_clkdiv <= 1'b0;
                    end else if (r_num == '0) begin
                        r_ce     <= 1'b0;
                    end else begin
                        r_ce     <= 1'b1;
                        r_clkdiv <= ~r_clkdiv;
                    end
                end else if (sync) begin
                    r_acc    <= '0;
                    r_ce     <= 1'b0;
                    r_clkdiv <= 1'b0;
                end else if (w_hit) begin
                    r_ce       <= 1'b1;
                    r_acc      <= w_sum[ACC_W-1:0] - r_den;
                    r_clkdiv   <= ~r_clkdiv;
                    r_lock_cnt <= w_cnt_inc;
                    if (w_cnt_inc >= C_LOCK_PULSES) r_locked <= 1'b1;
                end else begin
                    r_ce  <= 1'b0;
                    r_acc <= w_sum[ACC_W-1:0];
                end
                if (w_accept_here) r_locked <= 1'b0;
            end
        end

        assign ce[i]     = r_ce;
        assign clkdiv[i] = r_clkdiv;
        assign locked[i] = r_locked;
    end

endmodule
`default_nettype wire

// File: tb/tb_frac_clken_gen.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// tb_frac_clken_gen : self-checking bench for frac_clken_gen (3 channels)
// Revision: 1.0
// ============================================================================
module tb_frac_clken_gen;

    localparam int CH  = 3;
    localparam int AW  = 16;
    localparam int CHW = 2;
    localparam logic [10:0] M_ALL = 11'h7FF;

    logic           clkin     = 1'b0;
    logic           rst_n     = 1'b0;
    logic           sync      = 1'b0;
    logic           cfg_valid = 1'b0;
    logic [CHW-1:0] cfg_ch    = '0;
    logic [AW-1:0]  cfg_num   = '0;
    logic [AW-1:0]  cfg_den   = '0;
    logic           cfg_ready;
    logic           cfg_err;
    logic [CH-1:0]  ce;
    logic [CH-1:0]  clkdiv;
    logic [CH-1:0]  locked;

    always #5 clkin = ~clkin;

    frac_clken_gen #(
        .CHANNELS(CH), .ACC_W(AW), .INIT_NUM(1), .INIT_DEN(2), .LOCK_PULSES(2)
    ) dut (
        .clkin(clkin), .rst_n(rst_n), .sync(sync),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch),
        .cfg_num(cfg_num), .cfg_den(cfg_den), .cfg_err(cfg_err),
        .ce(ce), .clkdiv(clkdiv), .locked(locked)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        logic [10:0] exp;
        logic [10:0] mask;
    } sb_t;
    sb_t sb[$];

    typedef struct {
        logic [AW-1:0]  num;
        logic [AW-1:0]  den;
        logic [CHW-1:0] ch;
        logic           exp_err;
    } cfg_vec_t;

    typedef struct {
        logic c;
        logic cd;
        logic lk;
    } rst_vec_t;

    function automatic logic [10:0] pk(logic err, logic rdy, logic [2:0] lk, logic [2:0] cd, logic [2:0] c);
        return {err, rdy, lk, cd, c};
    endfunction

    task automatic check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clkin);
        #1;
    endtask

    task automatic drain();
        sb_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if (((pk(cfg_err, cfg_ready, locked, clkdiv, ce) ^ e.exp) & e.mask) != '0) begin
                errors++;
                $display("FAIL %s: got %b expected %b (mask %b)", e.name,
                         pk(cfg_err, cfg_ready, locked, clkdiv, ce), e.exp, e.mask);
            end
        end
    endtask

    task automatic expect_after(string name, logic [10:0] exp, logic [10:0] mask);
        sb.push_back('{name, exp, mask});
        tick();
        drain();
    endtask

    task automatic expect_now(string name, logic [10:0] exp, logic [10:0] mask);
        sb.push_back('{name, exp, mask});
        drain();
    endtask

    task automatic cfg_send(logic [CHW-1:0] ch, int num, int den);
        cfg_ch    = ch;
        cfg_num   = AW'(num);
        cfg_den   = AW'(den);
        cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
    endtask

    task automatic wait_ready(string name);
        int n = 0;
        while (!cfg_ready && n < 40) begin
            tick();
            n++;
        end
        check(name, int'(cfg_ready), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        cfg_vec_t tbl[4];
        rst_vec_t rtab[8];
        logic [2:0] p4[10];
        logic [5:0] p5[6];
        int cnt0, cnt1, bad;
        logic prev0;

        tbl[0] = '{16'd5, 16'd4, 2'd1, 1'b1};
        tbl[1] = '{16'd3, 16'd0, 2'd0, 1'b1};
        tbl[2] = '{16'd1, 16'd2, 2'd3, 1'b1};
        tbl[3] = '{16'd1, 16'd1, 2'd2, 1'b0};
        rtab[0] = '{1'b0, 1'b0, 1'b0};
        rtab[1] = '{1'b1, 1'b1, 1'b0};
        rtab[2] = '{1'b0, 1'b1, 1'b0};
        rtab[3] = '{1'b1, 1'b0, 1'b1};
        rtab[4] = '{1'b0, 1'b0, 1'b1};
        rtab[5] = '{1'b1, 1'b1, 1'b1};
        rtab[6] = '{1'b0, 1'b1, 1'b1};
        rtab[7] = '{1'b1, 1'b0, 1'b1};
        // {ce0, ready, locked0} for 1/8 -> 1/2 reconfigure starting at acc=3
        p4 = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b110,
               3'b010, 3'b110, 3'b010, 3'b111, 3'b011};
        // {ce[2:0], clkdiv[2:0]} after a one-cycle sync with 1/3, 1/5, 1/1
        p5 = '{6'b100_100, 6'b100_000, 6'b101_101, 6'b100_001, 6'b110_111, 6'b101_010};

        // reset state
        #3;
        expect_now("reset_state", pk(1'b0, 1'b1, 3'b000, 3'b000, 3'b000), M_ALL);
        @(posedge clkin);
        #1;
        rst_n = 1'b1;

        // default 1/2 on all channels
        for (int k = 0; k < 8; k++)
            expect_after($sformatf("default_edge%0d", k + 1),
                         pk(1'b0, 1'b1, {3{rtab[k].lk}}, {3{rtab[k].cd}}, {3{rtab[k].c}}), M_ALL);

        // config requests: three rejects then ch2 -> 1/1
        for (int k = 0; k < 4; k++) begin
            cfg_send(tbl[k].ch, int'(tbl[k].num), int'(tbl[k].den));
            check($sformatf("cfg_err_rec%0d", k), int'(cfg_err), int'(tbl[k].exp_err));
            check($sformatf("cfg_ready_rec%0d", k), int'(cfg_ready), int'(tbl[k].exp_err));
            if (tbl[k].exp_err) begin
                check($sformatf("locked_kept_rec%0d", k), int'(locked), 7);
                tick();
                check($sformatf("cfg_err_clear_rec%0d", k), int'(cfg_err), 0);
            end else begin
                wait_ready("ch2_1of1_apply");
            end
        end
        for (int k = 0; k < 4; k++) begin
            tick();
            check($sformatf("ch2_full_rate%0d", k), int'(ce[2]), 1);
        end

        // ch1 -> 3/7, ch0 keeps alternating
        prev0 = ce[0];
        bad   = 0;
        cfg_send(2'd1, 3, 7);
        check("ch1_accept_ready_low", int'(cfg_ready), 0);
        check("ch1_accept_unlock", int'(locked[1]), 0);
        if (ce[0] == prev0) bad++;
        prev0 = ce[0];
        begin
            int n = 0;
            while (!cfg_ready && n < 20) begin
                tick();
                n++;
                if (ce[0] == prev0) bad++;
                prev0 = ce[0];
            end
        end
        check("ch1_apply_ready", int'(cfg_ready), 1);
        check("ch1_apply_pulse", int'(ce[1]), 1);
        cnt0 = 0;
        cnt1 = 0;
        for (int k = 0; k < 700; k++) begin
            tick();
            cnt0 += int'(ce[0]);
            cnt1 += int'(ce[1]);
            if (ce[0] == prev0) bad++;
            prev0 = ce[0];
        end
        check("ch1_3of7_count", cnt1, 300);
        check("ch0_1of2_count", cnt0, 350);
        check("ch0_undisturbed", bad, 0);
        check("ch1_relocked", int'(locked[1]), 1);

        // ch0 1/8 -> 1/2 mid-period
        cfg_send(2'd0, 1, 8);
        wait_ready("ch0_1of8_apply");
        cnt0 = 0;
        for (int k = 0; k < 19; k++) begin
            tick();
            cnt0 += int'(ce[0]);
        end
        check("ch0_1of8_pulses", cnt0, 2);
        check("ch0_1of8_locked", int'(locked[0]), 1);
        cfg_ch    = 2'd0;
        cfg_num   = 16'd1;
        cfg_den   = 16'd2;
        cfg_valid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            expect_after($sformatf("reconf_edge%0d", k),
                         pk(1'b0, p4[k][1], {2'b00, p4[k][0]}, 3'b000, {2'b00, p4[k][2]}), 11'h241);
            cfg_valid = 1'b0;
        end

        // sync alignment of 1/3, 1/5, 1/1
        cfg_send(2'd0, 1, 3);
        wait_ready("ch0_1of3_apply");
        cfg_send(2'd1, 1, 5);
        wait_ready("ch1_1of5_apply");
        for (int k = 0; k < 12; k++) tick();
        sync = 1'b1;
        expect_after("sync_clear", pk(1'b0, 1'b1, 3'b111, 3'b000, 3'b000), M_ALL);
        sync = 1'b0;
        for (int k = 0; k < 6; k++)
            expect_after($sformatf("post_sync_edge%0d", k + 1),
                         pk(1'b0, 1'b1, 3'b111, p5[k][2:0], p5[k][5:3]), M_ALL);

        // num==0 idles the channel; leaving it applies on the next edge
        cfg_send(2'd2, 0, 4);
        wait_ready("ch2_0of4_apply");
        cnt0 = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            cnt0 += int'(ce[2]);
        end
        check("ch2_idle_no_pulses", cnt0, 0);
        check("ch2_idle_unlocked", int'(locked[2]), 0);
        cfg_ch    = 2'd2;
        cfg_num   = 16'd1;
        cfg_den   = 16'd2;
        cfg_valid = 1'b1;
        expect_after("from_zero_accept", pk(1'b0, 1'b0, 3'b000, 3'b000, 3'b000), 11'h204);
        cfg_valid = 1'b0;
        expect_after("from_zero_apply", pk(1'b0, 1'b1, 3'b000, 3'b000, 3'b000), 11'h204);
        expect_after("from_zero_edge2", pk(1'b0, 1'b1, 3'b000, 3'b000, 3'b000), 11'h204);
        expect_after("from_zero_edge3", pk(1'b0, 1'b1, 3'b000, 3'b000, 3'b100), 11'h204);

        // async reset while a request is pending
        cfg_send(2'd1, 1, 1);
        check("pend_before_reset", int'(cfg_ready), 0);
        #2;
        rst_n = 1'b0;
        #1;
        expect_now("async_reset", pk(1'b0, 1'b1, 3'b000, 3'b000, 3'b000), M_ALL);
        @(posedge clkin);
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++)
            expect_after($sformatf("post_reset_edge%0d", k + 1),
                         pk(1'b0, 1'b1, {3{rtab[k].lk}}, {3{rtab[k].cd}}, {3{rtab[k].c}}), M_ALL);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
